// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Count-width helper sizes the iteration counter.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   localparam int DEF_WIDTH = 8;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Operand and result handshake bundle for restoring_divider.
// The ovf signal exists only when DIV_OVF_EARLY_EN is defined.
interface restoring_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] dividend;
   logic [WIDTH-1:0]   divisor;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
`ifdef DIV_OVF_EARLY_EN
   logic               ovf;
`endif

   modport master (
      output in_valid,
      output dividend,
      output divisor,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  quotient,
`ifdef DIV_OVF_EARLY_EN
      input  ovf,
`endif
      input  remainder
   );

   modport slave (
      input  in_valid,
      input  dividend,
      input  divisor,
      input  out_ready,
      output in_ready,
      output out_valid,
      output quotient,
`ifdef DIV_OVF_EARLY_EN
      output ovf,
`endif
      output remainder
   );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,q},
// trial-subtract the divisor and restore on borrow.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH+1:0] sh;
   logic [WIDTH+1:0] trial;
   logic             neg;

   // One extra guard bit keeps the borrow visible for any rem value
   assign sh    = {rem_i, q_i[WIDTH-1]};
   assign trial = sh - {2'b00, divisor_i};
   assign neg   = trial[WIDTH+1];
   assign rem_o = neg ? sh[WIDTH:0] : trial[WIDTH:0];
   assign q_o   = {q_i[WIDTH-2:0], ~neg};

endmodule

// File: rtl/restoring_divider.sv
// Sequential 2W/W restoring divider, one quotient bit per clock.
// DIV_OVF_EARLY_EN adds early overflow detection and the ovf output.
module restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   restoring_divider_if.slave bus
);

   localparam int CW = cnt_w(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] hi;
   logic             skip;
   logic             ovf_q, ovf_d;

   assign hi = bus.dividend[2*WIDTH-1:WIDTH];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .q_i       (q_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

`ifdef DIV_OVF_EARLY_EN
   assign skip    = ovf_q;
   assign bus.ovf = ovf_q;
`else
   assign skip    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               rem_d   = {1'b0, hi};
               q_d     = bus.dividend[WIDTH-1:0];
               dvs_d   = bus.divisor;
               cnt_d   = CW'(WIDTH);
               ovf_d   = 1'b0;
`ifdef DIV_OVF_EARLY_EN
               ovf_d   = (hi >= bus.divisor);
`endif
               state_d = CALC;
            end
         end
         CALC: begin
            if (skip) begin
               // Saturated result, no iterations
               q_d     = '1;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               rem_d = step_rem;
               q_d   = step_q;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.quotient  = q_q;
   assign bus.remainder = rem_q[WIDTH-1:0];

endmodule

// File: tb/tb_restoring_divider.sv
// Directed table plus corner sequences for restoring_divider.
// Overflow checks are built only with DIV_OVF_EARLY_EN.
module tb_restoring_divider;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   restoring_divider_if #(.WIDTH(8)) bus ();

   restoring_divider #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dd;
      logic [7:0]  dv;
      logic [7:0]  q;
      logic [7:0]  r;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Starts and ends just after a falling edge
   task automatic run_op(input logic [15:0] dd,
                         input logic [7:0] dv,
                         input bit rnd,
                         output logic [7:0] q,
                         output logic [7:0] r,
                         output logic ov,
                         output int lat);
      int  n;
      int  w;
      bit  rdy_hi;
      bit  unstable;
      bit  go;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.dividend = dd;
      bus.divisor  = dv;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
      lat    = 0;
      rdy_hi = 1'b0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.in_ready) rdy_hi = 1'b1;
      end while (!bus.out_valid && lat < 50);
      chk("out_valid_wait", 32'(bus.out_valid), 32'd1);
      chk("in_ready_busy", 32'(rdy_hi), 32'd0);
      q = bus.quotient;
      r = bus.remainder;
`ifdef DIV_OVF_EARLY_EN
      ov = bus.ovf;
`else
      ov = 1'b0;
`endif
      w        = 0;
      unstable = 1'b0;
      do begin
         go = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (w >= 20) go = 1'b1;
         bus.out_ready = go;
         @(posedge clk);
         @(negedge clk);
         w++;
         if (!go && (bus.quotient !== q ||
                     bus.remainder !== r ||
                     bus.out_valid !== 1'b1 ||
                     bus.in_ready !== 1'b0))
            unstable = 1'b1;
      end while (!go);
      bus.out_ready = 1'b0;
      if (rnd) chk("hold_stable", 32'(unstable), 32'd0);
      chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  q;
      logic [7:0]  r;
      logic        ov;
      int          lat;
      int          n;
      logic [15:0] dd;
      logic [7:0]  dv;
      logic [7:0]  hi;

      total = 0;
      bad   = 0;
      vecs[0] = '{16'd1000,  8'd7,    8'd142, 8'd6};
      vecs[1] = '{16'hFEFF,  8'd255,  8'd255, 8'd254};
      vecs[2] = '{16'd100,   8'd3,    8'd33,  8'd1};
      vecs[3] = '{16'd0,     8'd5,    8'd0,   8'd0};
      vecs[4] = '{16'h00FF,  8'd1,    8'd255, 8'd0};
      vecs[5] = '{16'h1234,  8'h13,   8'd245, 8'd5};
      vecs[6] = '{16'h8000,  8'h81,   8'd254, 8'd2};
      vecs[7] = '{16'd7,     8'd8,    8'd0,   8'd7};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      #3;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_quotient", 32'(bus.quotient), 32'd0);
      chk("rst_remainder", 32'(bus.remainder), 32'd0);
`ifdef DIV_OVF_EARLY_EN
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].dd, vecs[i].dv, 1'b0, q, r, ov, lat);
         chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
         chk($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].r));
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
`ifdef DIV_OVF_EARLY_EN
         chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'd0);
`endif
      end

      // Result held with out_ready low while inputs wander
      bus.dividend  = 16'd1000;
      bus.divisor   = 8'd7;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 50);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         bus.dividend = 16'($urandom);
         bus.divisor  = 8'($urandom);
         bus.in_valid = 1'b1;
         @(negedge clk);
         chk("hold_q", 32'(bus.quotient), 32'd142);
         chk("hold_r", 32'(bus.remainder), 32'd6);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("hold_release", 32'(bus.in_ready), 32'd1);

      // Reset pulse in the middle of CALC
      bus.dividend = 16'd1000;
      bus.divisor  = 8'd7;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_q", 32'(bus.quotient), 32'd0);
      chk("mid_rst_r", 32'(bus.remainder), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      run_op(16'd100, 8'd3, 1'b0, q, r, ov, lat);
      chk("after_rst_q", 32'(q), 32'd33);
      chk("after_rst_r", 32'(r), 32'd1);

`ifdef DIV_OVF_EARLY_EN
      run_op(16'hFFFF, 8'd255, 1'b0, q, r, ov, lat);
      chk("ovf1_q", 32'(q), 32'hFF);
      chk("ovf1_r", 32'(r), 32'd0);
      chk("ovf1_ovf", 32'(ov), 32'd1);
      chk("ovf1_lat", 32'(lat), 32'd1);
      run_op(16'h1234, 8'd0, 1'b0, q, r, ov, lat);
      chk("ovf0_q", 32'(q), 32'hFF);
      chk("ovf0_r", 32'(r), 32'd0);
      chk("ovf0_ovf", 32'(ov), 32'd1);
      chk("ovf0_lat", 32'(lat), 32'd1);
`endif

      // Random exact-range operands with random consumer stalls
      for (int i = 0; i < 16; i++) begin
         dv = 8'($urandom_range(1, 255));
         hi = 8'($urandom_range(0, int'(dv) - 1));
         dd = {hi, 8'($urandom)};
         run_op(dd, dv, 1'b1, q, r, ov, lat);
         chk("rand_identity", 32'(q) * 32'(dv) + 32'(r),
             32'(dd));
         chk("rand_r_lt_d", 32'(r < dv), 32'd1);
         chk("rand_lat", 32'(lat), 32'd8);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential restoring divider: the inverse of the team's 2N-by-N-bit recursive multipliers. It divides a 2·WIDTH-bit dividend by a WIDTH-bit divisor and returns a WIDTH-bit quotient and remainder, one quotient bit per clock. It is used as the exact reference and companion datapath for the approximate multiplier arrays, for example in product-recovery checks of the form Y / b == a. Operands enter through a valid/ready handshake and results leave through one.

## Interface
- WIDTH, 8: divisor, quotient and remainder width. The dividend is 2·WIDTH bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  dividend and divisor are valid
- in_ready  out  1  block can accept an operand pair; high only in IDLE
- dividend  in  2·WIDTH  numerator, unsigned
- divisor  in  WIDTH  denominator, unsigned
- out_valid  out  1  quotient, remainder and ovf are valid
- out_ready  in  1  consumer accepts the result
- quotient  out  WIDTH  unsigned quotient
- remainder  out  WIDTH  unsigned remainder
- ovf  out  1  quotient does not fit in WIDTH bits (includes divide-by-zero). Present only with DIV_OVF_EARLY_EN.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: WIDTH iterations.
  - DONE: out_valid=1.
- IDLE → CALC on in_valid && in_ready.
  - Load rem = dividend[2W-1:W] into a WIDTH+1-bit register.
  - Load q = dividend[W-1:0].
  - Latch divisor; cnt = WIDTH.
- CALC, each cycle:
  - {rem, q} <<= 1.
  - trial = rem − divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and q[0] = 1.
  - cnt decrements.
  - When cnt reaches 1, the transition to DONE happens on the same edge.
- DONE:
  - quotient = q, remainder = rem[W-1:0], both held stable until out_valid && out_ready.
  - The handshake edge moves the block to IDLE.
- Inputs are sampled only on the accept edge. Changes on dividend/divisor during CALC/DONE are ignored.
- Result is exact when dividend[2W-1:W] < divisor: dividend == quotient·divisor + remainder, and remainder < divisor.
- Without the overflow feature, quotient/remainder for overflowing operands are whatever WIDTH iterations produce. They are unchecked.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, out_valid=0, quotient=0, remainder=0, ovf=0, cnt=0.
  - in_ready=1 on the first cycle after reset release.
- Reset mid-CALC or mid-DONE: the operation is abandoned and no result is produced.
- Latency: accept edge at edge 0; iterations at edges 1..WIDTH; out_valid high after edge WIDTH.
- out_ready high while out_valid is high: the result is consumed at the next edge, and in_ready rises in the following cycle.
- Minimum operation-to-operation period: WIDTH+2 cycles. The block does not accept a new operand during DONE.
- out_ready may be held low indefinitely. All outputs stay stable.
- out_ready is ignored while out_valid=0.

## Configuration
- DIV_OVF_EARLY_EN defined:
  - On accept, overflow = (dividend[2W-1:W] >= divisor), which includes divisor==0.
  - If overflow is set, CALC is skipped: DONE is entered on edge 1 with quotient=all-ones, remainder=0, ovf=1.
  - Otherwise ovf=0 and timing is as above.
- DIV_OVF_EARLY_EN undefined:
  - No ovf port.
  - Every operation takes WIDTH iterations.

## Structure
- Package div_pkg:
  - State enum {IDLE, CALC, DONE}.
  - Default WIDTH constant.
  - Count-width function clog2(WIDTH+1).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: {rem, q}, divisor.
  - Outputs: next rem, next q.
  - Reusable for a later unrolled/pipelined variant.
- The top level holds the FSM, counter and registers.

## Test plan
- dividend=1000 (0x03E8), divisor=7, out_ready=1 → out_valid exactly 8 cycles after accept; quotient=142, remainder=6, ovf=0.
- dividend=0xFEFF, divisor=255 → quotient=255, remainder=254.
- Randomized back-to-back operands with dividend[15:8] < divisor, out_ready toggled randomly → every result satisfies q·d+r==dividend and r<d; no lost or duplicated results; in_ready never high outside IDLE.
- With DIV_OVF_EARLY_EN: dividend=0xFFFF, divisor=255, and separately dividend=0x1234, divisor=0 → out_valid 1 cycle after accept; quotient=0xFF, remainder=0, ovf=1.
- out_ready held low 5 cycles in DONE while dividend/divisor inputs change → quotient/remainder unchanged; in_ready stays 0 until the handshake.
- rst_n pulsed low 3 cycles into CALC → all outputs 0 immediately; in_ready=1 after release; the next operation (100/3) gives quotient=33, remainder=1.
